// File: rtl/nand_latch_pkg.sv
// Shared types and constants for the clock-synchronous gated NAND SR latch.
package nand_latch_pkg;

    typedef enum logic [1:0] {
        ST_RESET   = 2'b00,
        ST_SET     = 2'b01,
        ST_INVALID = 2'b10
    } state_e;

    localparam state_e RESET_STATE = ST_RESET;

    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/nand_latch_sat_cnt.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on rst.
module nand_latch_sat_cnt #(
    parameter int W = nand_latch_pkg::CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nand_latch.sv
// Clock-synchronous gated NAND SR latch with forbidden-input detection.
// Define NAND_LATCH_STATS_EN to add the set/reset/invalid entry counters.
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_RESET   | stored 0: q=0, qn=1
// ST_SET     | stored 1: q=1, qn=0
// ST_INVALID | s=r=1 seen under en: q=1, qn=1, invalid=1
module nand_latch
    import nand_latch_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             s,
    input  logic             r,
    output logic             q,
    output logic             qn,
`ifdef NAND_LATCH_STATS_EN
    output logic [CNT_W-1:0] set_cnt,
    output logic [CNT_W-1:0] rst_cnt,
    output logic [CNT_W-1:0] inv_cnt,
`endif
    output logic             invalid
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("nand_latch: CNT_W must be at least 1");
    end

    state_e state;
    state_e state_nxt;

    // A valid set/reset on the same edge wins over the forced exit from INVALID.
    always_comb begin
        state_nxt = state;
        if (en && s && !r) begin
            state_nxt = ST_SET;
        end else if (en && !s && r) begin
            state_nxt = ST_RESET;
        end else if (en && s && r) begin
            state_nxt = ST_INVALID;
        end else if (state == ST_INVALID) begin
            state_nxt = ST_RESET;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    assign q       = (state != ST_RESET);
    assign qn      = (state != ST_SET);
    assign invalid = (state == ST_INVALID);

`ifdef NAND_LATCH_STATS_EN
    logic inc_set;
    logic inc_rst;
    logic inc_inv;

    assign inc_set = (state_nxt == ST_SET)     && (state != ST_SET);
    assign inc_rst = (state_nxt == ST_RESET)   && (state != ST_RESET);
    assign inc_inv = (state_nxt == ST_INVALID) && (state != ST_INVALID);

    nand_latch_sat_cnt #(.W(CNT_W)) u_set_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc_set),
        .cnt (set_cnt)
    );

    nand_latch_sat_cnt #(.W(CNT_W)) u_rst_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc_rst),
        .cnt (rst_cnt)
    );

    nand_latch_sat_cnt #(.W(CNT_W)) u_inv_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc_inv),
        .cnt (inv_cnt)
    );
`endif

endmodule

// File: tb/tb_nand_latch.sv
// Self-checking bench for nand_latch; counter checks compile in with NAND_LATCH_STATS_EN.
module tb_nand_latch;

    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic s   = 1'b0;
    logic r   = 1'b0;
    logic q;
    logic qn;
    logic invalid;
`ifdef NAND_LATCH_STATS_EN
    logic [CW-1:0] set_cnt;
    logic [CW-1:0] rst_cnt;
    logic [CW-1:0] inv_cnt;
`endif

    int n_checks = 0;
    int n_passed = 0;

    // Reference: stored bit plus a "both outputs high" flag, and entry counts.
    int m_q   = 0;
    int m_inv = 0;
    int m_set_cnt = 0;
    int m_rst_cnt = 0;
    int m_inv_cnt = 0;
    int cnt_max = (1 << CW) - 1;

    nand_latch #(.CNT_W(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .s       (s),
        .r       (r),
        .q       (q),
        .qn      (qn),
`ifdef NAND_LATCH_STATS_EN
        .set_cnt (set_cnt),
        .rst_cnt (rst_cnt),
        .inv_cnt (inv_cnt),
`endif
        .invalid (invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int label(input int qv, input int iv);
        return iv ? 2 : (qv ? 1 : 0);
    endfunction

    task automatic model_reset();
        m_q = 0;
        m_inv = 0;
        m_set_cnt = 0;
        m_rst_cnt = 0;
        m_inv_cnt = 0;
    endtask

    task automatic model_edge(input logic e, input logic sv, input logic rv);
        int prev;
        int now;
        prev = label(m_q, m_inv);
        if (e && sv && rv) begin
            m_q = 1; m_inv = 1;
        end else if (e && sv) begin
            m_q = 1; m_inv = 0;
        end else if (e && rv) begin
            m_q = 0; m_inv = 0;
        end else if (m_inv != 0) begin
            m_q = 0; m_inv = 0;
        end
        now = label(m_q, m_inv);
        if (now != prev) begin
            if (now == 1 && m_set_cnt < cnt_max) m_set_cnt++;
            if (now == 0 && m_rst_cnt < cnt_max) m_rst_cnt++;
            if (now == 2 && m_inv_cnt < cnt_max) m_inv_cnt++;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".q"}, int'(q), m_q);
        check({tag, ".qn"}, int'(qn), (m_inv != 0) ? 1 : 1 - m_q);
        check({tag, ".invalid"}, int'(invalid), m_inv);
`ifdef NAND_LATCH_STATS_EN
        check({tag, ".set_cnt"}, int'(set_cnt), m_set_cnt);
        check({tag, ".rst_cnt"}, int'(rst_cnt), m_rst_cnt);
        check({tag, ".inv_cnt"}, int'(inv_cnt), m_inv_cnt);
`endif
    endtask

    // Drive at the falling edge (with a glitch first), sample 1ns after the rising edge.
    task automatic step(input string tag, input logic e, input logic sv, input logic rv);
        @(negedge clk);
        en = $urandom_range(0, 1);
        s  = $urandom_range(0, 1);
        r  = $urandom_range(0, 1);
        #1;
        en = e; s = sv; r = rv;
        @(posedge clk);
        model_edge(e, sv, rv);
        #1;
        check_outputs(tag);
    endtask

    task automatic pulse_reset(input string tag);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs(tag);
        rst = 1'b0;
    endtask

    initial begin
        // Reset with no clock edge nearby.
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("rst_async");
        rst = 1'b0;

        // Disabled inputs must not disturb ST_RESET.
        step("hold_dis_s",  1'b0, 1'b1, 1'b0);
        step("hold_dis_r",  1'b0, 1'b0, 1'b1);
        step("hold_dis_sr", 1'b0, 1'b1, 1'b1);

        step("set",         1'b1, 1'b1, 1'b0);
        check("set_q_const", int'(q), 1);
        step("hold_en",     1'b1, 1'b0, 1'b0);
        step("hold_dis",    1'b0, 1'b0, 1'b1);
        check("hold_dis_q_const", int'(q), 1);
        step("reset",       1'b1, 1'b0, 1'b1);
        check("reset_q_const", int'(q), 0);

        step("inv",         1'b1, 1'b1, 1'b1);
        check("inv_qn_const", int'(qn), 1);
        step("inv_rel_dis", 1'b0, 1'b1, 1'b1);
        check("inv_rel_q_const", int'(q), 0);
        step("inv2",        1'b1, 1'b1, 1'b1);
        step("inv_rel_set", 1'b1, 1'b1, 1'b0);
        check("inv_set_qn_const", int'(qn), 0);

        // Reset while a set is held on the inputs.
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("rst_mid");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_outputs("rst_held");
        end
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1; s = 1'b1; r = 1'b0;
        @(posedge clk);
        model_edge(1'b1, 1'b1, 1'b0);
        #1;
        check_outputs("rst_release");
        check("rst_release_q_const", int'(q), 1);

`ifdef NAND_LATCH_STATS_EN
        pulse_reset("stats_rst");
        for (int i = 0; i < 5; i++) begin
            step("stats_set", 1'b1, 1'b1, 1'b0);
            step("stats_rst", 1'b1, 1'b0, 1'b1);
        end
        check("stats_set_sat", int'(set_cnt), 3);
        check("stats_rst_sat", int'(rst_cnt), 3);
        step("stats_inv", 1'b1, 1'b1, 1'b1);
        check("stats_inv_one", int'(inv_cnt), 1);
`endif

        // Random traffic with occasional mid-cycle resets.
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 29) == 0) pulse_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
